// File: rtl/interval_timer_bank_if.sv
// Control/status bundle for interval_timer_bank: shadow-register load port,
// per-channel strobes and per-channel expiry/run indicators.
interface interval_timer_bank_if #(
    parameter int WIDTH    = 33,
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                load;
    logic [CH_BITS-1:0]  load_ch;
    logic [WIDTH-1:0]    load_cycles;
    logic                load_periodic;
    logic [CHANNELS-1:0] start;
    logic [CHANNELS-1:0] stop;
    logic [CHANNELS-1:0] clear;
    logic [CHANNELS-1:0] flag;
    logic [CHANNELS-1:0] status;
    logic [CHANNELS-1:0] busy;

    modport master (
        output load, load_ch, load_cycles, load_periodic, start, stop, clear,
        input  flag, status, busy
    );

    modport slave (
        input  load, load_ch, load_cycles, load_periodic, start, stop, clear,
        output flag, status, busy
    );
endinterface

// File: rtl/interval_timer_bank.sv
// Multi-channel programmable interval timer: each channel counts to a shadowed
// terminal count in one-shot or periodic mode, pulsing flag and setting status on expiry.
module itb_channel #(
    parameter int WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_hit,
    input  logic [WIDTH-1:0] load_cycles,
    input  logic             load_periodic,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic             flag,
    output logic             status,
    output logic             busy
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] shadow_n_q, shadow_n_d;
    logic [WIDTH-1:0] active_n_q, active_n_d;
    logic             shadow_mode_q, shadow_mode_d;
    logic             active_mode_q, active_mode_d;
    logic             flag_q, flag_d;
    logic             status_q, status_d;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        shadow_n_d    = shadow_n_q;
        shadow_mode_d = shadow_mode_q;
        active_n_d    = active_n_q;
        active_mode_d = active_mode_q;
        flag_d        = 1'b0;

        if (load_hit) begin
            shadow_n_d    = load_cycles;
            shadow_mode_d = load_periodic;
        end

        // Arm and wrap copy the pre-edge shadow, so a same-cycle load lands on the next one.
        if (stop) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start) begin
            state_d       = RUN;
            count_d       = '0;
            active_n_d    = shadow_n_q;
            active_mode_d = shadow_mode_q;
        end else if (state_q == RUN) begin
            if (count_q == active_n_q) begin
                flag_d  = 1'b1;
                count_d = '0;
                if (active_mode_q) begin
                    active_n_d    = shadow_n_q;
                    active_mode_d = shadow_mode_q;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end

        status_d = status_q;
        if (clear)  status_d = 1'b0;
        if (flag_d) status_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            shadow_n_q    <= '0;
            shadow_mode_q <= 1'b0;
            active_n_q    <= '0;
            active_mode_q <= 1'b0;
            flag_q        <= 1'b0;
            status_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            shadow_n_q    <= shadow_n_d;
            shadow_mode_q <= shadow_mode_d;
            active_n_q    <= active_n_d;
            active_mode_q <= active_mode_d;
            flag_q        <= flag_d;
            status_q      <= status_d;
        end
    end

    assign flag   = flag_q;
    assign status = status_q;
    assign busy   = (state_q == RUN);
endmodule

module interval_timer_bank #(
    parameter int WIDTH    = 33,
    parameter int CHANNELS = 4
) (
    input logic                  clock,
    input logic                  reset,
    interval_timer_bank_if.slave bus
);
    localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] flag_w;
    logic [CHANNELS-1:0] status_w;
    logic [CHANNELS-1:0] busy_w;

    // Only channels 0..CHANNELS-1 exist, so an out-of-range load_ch matches nothing.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        itb_channel #(.WIDTH(WIDTH)) u_ch (
            .clock         (clock),
            .reset         (reset),
            .load_hit      (bus.load && (bus.load_ch == CH_BITS'(i))),
            .load_cycles   (bus.load_cycles),
            .load_periodic (bus.load_periodic),
            .start         (bus.start[i]),
            .stop          (bus.stop[i]),
            .clear         (bus.clear[i]),
            .flag          (flag_w[i]),
            .status        (status_w[i]),
            .busy          (busy_w[i])
        );
    end

    assign bus.flag   = flag_w;
    assign bus.status = status_w;
    assign bus.busy   = busy_w;
endmodule
